// File: rtl/regfile_pkg.sv
// Shared constants for the register file with issue-time busy scoreboard.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned ZERO_REG  = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: per-register pending-write flags, their popcount and a sticky
// error for writes that arrive at a register nobody reserved.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          alloc_en,
  input  logic [AW-1:0] alloc_addr,
  input  logic          flush,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic          rd_busy_a,
  output logic          rd_busy_b,
  output logic [AW:0]   busy_count,
  output logic          err_unalloc
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [AW:0]      count_d;
  logic             wr_hit;
  logic             alloc_hit;
  logic             same_dst;
  logic             err_set;

  assign wr_hit    = wr_en && (wr_addr != AW'(ZERO_REG));
  assign alloc_hit = alloc_en && (alloc_addr != AW'(ZERO_REG));
  assign same_dst  = wr_hit && alloc_hit && (wr_addr == alloc_addr);

  // Allocation is applied after the write clear so a new producer wins; flush wins over both.
  always_comb begin
    busy_d = busy_q;
    if (wr_hit) busy_d[wr_addr] = 1'b0;
    if (alloc_hit) busy_d[alloc_addr] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[AW'(ZERO_REG)] = 1'b0;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + (AW + 1)'(busy_d[i]);
    end
  end

  assign err_set = wr_hit && !busy_q[wr_addr] && !flush && !same_dst;

  // A same-cycle write releases the register early unless it is re-reserved this cycle.
  assign rd_busy_a = busy_q[rd_addr_a] &&
                     !(wr_hit && (wr_addr == rd_addr_a) &&
                       !(alloc_hit && (alloc_addr == rd_addr_a)));
  assign rd_busy_b = busy_q[rd_addr_b] &&
                     !(wr_hit && (wr_addr == rd_addr_b) &&
                       !(alloc_hit && (alloc_addr == rd_addr_b)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      busy_count  <= '0;
      err_unalloc <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      busy_count <= count_d;
      if (err_set) err_unalloc <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write-to-read bypass, R0 hardwired to zero,
// and a busy scoreboard tracking outstanding destination reservations.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_busy_a,
  output logic             rd_busy_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             alloc_en,
  input  logic [AW-1:0]    alloc_addr,
  input  logic             flush,
  output logic [AW:0]      busy_count,
  output logic             err_unalloc
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic             wr_hit;

  assign wr_hit = wr_en && (wr_addr != AW'(ZERO_REG));

  // R0 is never written, so its reset value keeps it reading as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (wr_hit && (wr_addr == rd_addr_a)) ? wr_data : regs_q[rd_addr_a];
  assign rd_data_b = (wr_hit && (wr_addr == rd_addr_b)) ? wr_data : regs_q[rd_addr_b];

  rf_scoreboard #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_busy_a  (rd_busy_a),
    .rd_busy_b  (rd_busy_b),
    .busy_count (busy_count),
    .err_unalloc(err_unalloc)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: vector table with same-cycle read checks and a queue of post-edge
// expectations, plus hand-written reset sequences.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        rd_busy_a;
  logic        rd_busy_b;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        alloc_en;
  logic [2:0]  alloc_addr;
  logic        flush;
  logic [3:0]  busy_count;
  logic        err_unalloc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        ae;
    logic [2:0]  aa;
    logic        fl;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] exp_da;
    logic        exp_ba;
    logic [15:0] exp_db;
    logic        exp_bb;
    logic [3:0]  exp_cnt;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [3:0] cnt;
    logic       err;
  } post_t;

  vec_t  vecs [17];
  post_t post_q [$];

  regfile_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .rd_busy_a  (rd_busy_a),
    .rd_busy_b  (rd_busy_b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy_count (busy_count),
    .err_unalloc(err_unalloc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                              input logic ae, input logic [2:0] aa, input logic fl,
                              input logic [2:0] ra, input logic [2:0] rb,
                              input logic [15:0] da, input logic ba,
                              input logic [15:0] db, input logic bb,
                              input logic [3:0] cnt, input logic err);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ae = ae; v.aa = aa; v.fl = fl;
    v.ra = ra; v.rb = rb; v.exp_da = da; v.exp_ba = ba; v.exp_db = db; v.exp_bb = bb;
    v.exp_cnt = cnt; v.exp_err = err;
    return v;
  endfunction

  initial begin
    post_t p;
    //            we wa  wd       ae aa fl ra rb  da       ba db       bb cnt err
    vecs[0]  = mk(0, 0, 16'h0000, 0, 0, 0, 1, 2, 16'h0000, 0, 16'h0000, 0, 0, 0);
    vecs[1]  = mk(0, 0, 16'h0000, 1, 3, 0, 3, 0, 16'h0000, 0, 16'h0000, 0, 1, 0);
    vecs[2]  = mk(1, 3, 16'h1234, 0, 0, 0, 3, 3, 16'h1234, 0, 16'h1234, 0, 0, 0);
    vecs[3]  = mk(1, 5, 16'hBEEF, 1, 5, 0, 5, 3, 16'hBEEF, 0, 16'h1234, 0, 1, 0);
    vecs[4]  = mk(0, 0, 16'h0000, 0, 0, 0, 5, 0, 16'hBEEF, 1, 16'h0000, 0, 1, 0);
    vecs[5]  = mk(1, 0, 16'hFFFF, 1, 0, 0, 0, 5, 16'h0000, 0, 16'hBEEF, 1, 1, 0);
    vecs[6]  = mk(0, 0, 16'h0000, 1, 1, 0, 1, 2, 16'h0000, 0, 16'h0000, 0, 2, 0);
    vecs[7]  = mk(0, 0, 16'h0000, 1, 2, 0, 1, 2, 16'h0000, 1, 16'h0000, 0, 3, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 1, 4, 0, 2, 4, 16'h0000, 1, 16'h0000, 0, 4, 0);
    vecs[9]  = mk(0, 0, 16'h0000, 1, 6, 1, 4, 6, 16'h0000, 1, 16'h0000, 0, 0, 0);
    vecs[10] = mk(0, 0, 16'h0000, 0, 0, 0, 6, 1, 16'h0000, 0, 16'h0000, 0, 0, 0);
    vecs[11] = mk(1, 6, 16'h0AAA, 0, 0, 0, 6, 7, 16'h0AAA, 0, 16'h0000, 0, 0, 1);
    vecs[12] = mk(0, 0, 16'h0000, 1, 7, 0, 6, 7, 16'h0AAA, 0, 16'h0000, 0, 1, 1);
    vecs[13] = mk(0, 0, 16'h0000, 1, 7, 0, 7, 6, 16'h0000, 1, 16'h0AAA, 0, 1, 1);
    vecs[14] = mk(1, 7, 16'h5555, 1, 2, 0, 7, 2, 16'h5555, 0, 16'h0000, 0, 1, 1);
    vecs[15] = mk(1, 2, 16'h7777, 0, 0, 1, 2, 2, 16'h7777, 0, 16'h7777, 0, 0, 1);
    vecs[16] = mk(0, 0, 16'h0000, 1, 2, 0, 7, 3, 16'h5555, 0, 16'h1234, 0, 1, 1);

    idle();
    rd_addr_a = '0; rd_addr_b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Every address reads zero and idle right out of reset.
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a); rd_addr_b = 3'(7 - a);
      #1;
      check($sformatf("rst_da[%0d]", a), rd_data_a, 16'h0);
      check($sformatf("rst_db[%0d]", 7 - a), rd_data_b, 16'h0);
      check($sformatf("rst_ba[%0d]", a), 16'(rd_busy_a), 16'h0);
    end
    check("rst_cnt", 16'(busy_count), 16'h0);
    check("rst_err", 16'(err_unalloc), 16'h0);

    @(posedge clk);
    for (int i = 0; i < 17; i++) begin
      #1;
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      alloc_en = vecs[i].ae; alloc_addr = vecs[i].aa; flush = vecs[i].fl;
      rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
      p.cnt = vecs[i].exp_cnt; p.err = vecs[i].exp_err;
      post_q.push_back(p);
      #2;
      check($sformatf("v%0d_da", i), rd_data_a, vecs[i].exp_da);
      check($sformatf("v%0d_ba", i), 16'(rd_busy_a), 16'(vecs[i].exp_ba));
      check($sformatf("v%0d_db", i), rd_data_b, vecs[i].exp_db);
      check($sformatf("v%0d_bb", i), 16'(rd_busy_b), 16'(vecs[i].exp_bb));
      @(posedge clk);
      #1;
      idle();
      p = post_q.pop_front();
      check($sformatf("v%0d_cnt", i), 16'(busy_count), 16'(p.cnt));
      check($sformatf("v%0d_err", i), 16'(err_unalloc), 16'(p.err));
    end
    check("queue_empty", 16'(post_q.size()), 16'h0);

    // R2 is busy here; reset between edges must clear everything without a clock edge.
    rd_addr_a = 3'd3; rd_addr_b = 3'd2;
    #1;
    check("pre_async_bb", 16'(rd_busy_b), 16'h1);
    check("pre_async_da", rd_data_a, 16'h1234);
    rst_n = 1'b0;
    #1;
    check("async_da", rd_data_a, 16'h0);
    check("async_bb", 16'(rd_busy_b), 16'h0);
    check("async_cnt", 16'(busy_count), 16'h0);
    check("async_err", 16'(err_unalloc), 16'h0);

    // In-flight write and allocation under reset are discarded.
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h1111;
    alloc_en = 1'b1; alloc_addr = 3'd5;
    @(posedge clk);
    #2;
    idle();
    rst_n = 1'b1;
    rd_addr_a = 3'd4; rd_addr_b = 3'd5;
    #1;
    check("inflight_da", rd_data_a, 16'h0);
    check("inflight_bb", 16'(rd_busy_b), 16'h0);

    // First edge after deassertion behaves normally.
    alloc_en = 1'b1; alloc_addr = 3'd5;
    @(posedge clk);
    #1;
    idle();
    check("post_rst_cnt", 16'(busy_count), 16'h1);
    check("post_rst_bb", 16'(rd_busy_b), 16'h1);
    check("post_rst_err", 16'(err_unalloc), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter WIDTH, default 16: data width of each register, in bits.
REQ-002 Parameter DEPTH, default 8: number of registers; SHALL be a power of two and at least 4.
REQ-003 Parameter AW, default $clog2(DEPTH): register address width; derived from DEPTH, never overridden.
REQ-004 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Ports rd_addr_a and rd_addr_b, input, AW each: the two read-port addresses.
REQ-007 Ports rd_data_a and rd_data_b, output, WIDTH each: read data for ports A and B.
REQ-008 Ports rd_busy_a and rd_busy_b, output, 1 each: the addressed register has a write pending.
REQ-009 Ports wr_en (input, 1), wr_addr (input, AW) and wr_data (input, WIDTH): the write-back port.
REQ-010 Ports alloc_en (input, 1) and alloc_addr (input, AW): issue-time destination reservation.
REQ-011 Port flush, input, 1: clear all pending reservations.
REQ-012 Port busy_count, output, AW+1: number of registers currently marked busy.
REQ-013 Port err_unalloc, output, 1: sticky flag, set by a write to a register that is not busy.

Function
REQ-014 Register 0 SHALL always read as 0 and never be busy; writes and allocations to address 0 SHALL be discarded.
REQ-015 Reads SHALL be combinational; rd_data_x SHALL equal the stored value of rd_addr_x.
- Bypass: when wr_en=1, wr_addr equals rd_addr_x and wr_addr is not 0, rd_data_x SHALL equal wr_data in the same cycle.
REQ-016 rd_busy_x SHALL reflect the registered busy bit of rd_addr_x, with one exception: a same-cycle write to that address SHALL force rd_busy_x=0, unless a same-cycle allocation targets the same address.
REQ-017 A write SHALL update the register at the clock edge and clear its busy bit.
REQ-018 An allocation SHALL set the busy bit of alloc_addr at the clock edge.
REQ-019 When an allocation and a write target the same nonzero address in one cycle:
- the data SHALL be stored;
- the busy bit SHALL end set (the new producer wins).
REQ-020 Allocating a register that is already busy SHALL leave it busy; no error is raised.
REQ-021 flush=1 SHALL clear every busy bit at the edge, and SHALL override same-cycle allocations; a same-cycle write SHALL still store its data.
REQ-022 busy_count SHALL be registered and equal the popcount of the busy bits after each edge; its range is 0..DEPTH-1.
REQ-023 err_unalloc SHALL set, one cycle after the offending edge, when wr_en=1, wr_addr is nonzero and the busy bit is clear (flush and allocation in that cycle excepted).
- It SHALL remain set until reset.

Reset
REQ-024 rst_n=0 SHALL asynchronously clear all registers to 0, all busy bits, busy_count and err_unalloc.
REQ-025 Reset asserted mid-operation SHALL discard any in-flight write and allocation; the first edge after deassertion SHALL behave as normal.

Structure
REQ-026 Default WIDTH and DEPTH SHALL be constants in the shared package regfile_pkg, together with the ZERO_REG index (0).
REQ-027 One sub-module, rf_scoreboard, SHALL hold the busy bits, busy_count and err_unalloc logic.
- The data array and the bypass logic SHALL remain in the top module.

Verification
REQ-028 Reset, then read all addresses -> every read returns 0, rd_busy=0, busy_count=0, err_unalloc=0.
REQ-029 Allocate R3; next cycle write R3=0x1234 while reading A=R3 -> same cycle: rd_data_a=0x1234, rd_busy_a=0; after the edge: busy_count=0.
REQ-030 Allocate and write R5=0xBEEF in the same cycle -> R5 reads 0xBEEF, R5 stays busy, busy_count=1.
REQ-031 Write R0=0xFFFF with alloc_addr=0 -> R0 reads 0, busy_count unchanged, err_unalloc unchanged.
REQ-032 Allocate R1, R2 and R4, then assert flush together with an allocation of R6 -> busy_count=0 and R6 not busy; a subsequent write to R6 sets err_unalloc.
REQ-033 Assert rst_n low between clock edges while R2 is busy -> all outputs clear immediately, with no clock edge required.
